fifo_n2w: RTL and testbench

- Asymmetric synchronous FIFO that packs narrow writes into wide reads: DATA_WIDTH-bit write port, 2*DATA_WIDTH-bit read port.
- It is the counterpart of the team's wide-to-narrow FIFO. Byte-serial producers (UART rx, SPI rx) feed 16-bit consumers through it.
- Storage holds 2**ADDR_WIDTH narrow entries. Each read pops two entries.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_n2w_if.sv | 26 ++
 rtl/fifo_n2w_ctrl.sv | 45 ++++
 rtl/fifo_n2w.sv | 52 +++++
 tb/tb_fifo_n2w.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Definitions shared by the asymmetric FIFOs (narrow-to-wide and wide-to-narrow).
// Both FIFOs must agree on the packing order so that a round trip preserves byte order.
package fifo_pkg;

    // 1: the first narrow word occupies the low half of a wide word.
    localparam bit LOW_FIRST = 1'b1;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_n2w_if.sv
// Handshake bundle for the narrow-to-wide FIFO.
// The master side is the producer/consumer pair; the slave side is the FIFO itself.
interface fifo_n2w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);

    logic                      wr;
    logic [DATA_WIDTH-1:0]     w_data;
    logic                      rd;
    logic [2*DATA_WIDTH-1:0]   r_data;
    logic                      full;
    logic                      empty;
    logic [ADDR_WIDTH:0]       level;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, level
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, level
    );

endinterface

// File: rtl/fifo_n2w_ctrl.sv
// Pointer, occupancy and flag logic for the narrow-to-wide FIFO.
// Flags come from the level register alone, so wr/rd never reach them combinationally.
module fifo_n2w_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_ptr,
    output logic [ADDR_WIDTH-1:0] r_ptr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ok
);

    localparam int               LW         = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(depth(ADDR_WIDTH));

    logic rd_ok;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level < LW'(2));
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    // A read retires a whole wide word, so the read pointer steps by two and stays even.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            if (wr_ok)
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            if (rd_ok)
                r_ptr <= r_ptr + ADDR_WIDTH'(2);
            level <= level + LW'(wr_ok) - LW'({rd_ok, 1'b0});
        end
    end

endmodule

// File: rtl/fifo_n2w.sv
// Narrow-to-wide FIFO: packs pairs of DATA_WIDTH-bit writes into 2*DATA_WIDTH-bit reads.
// The head wide word falls through combinationally from the storage array.
module fifo_n2w
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input logic        clk,
    input logic        reset,
    fifo_n2w_if.slave  bus
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr_pair;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] first_word;
    logic [DATA_WIDTH-1:0] second_word;

    fifo_n2w_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.wr),
        .rd    (bus.rd),
        .w_ptr (w_ptr),
        .r_ptr (r_ptr),
        .level (bus.level),
        .full  (bus.full),
        .empty (bus.empty),
        .wr_ok (wr_ok)
    );

    // Storage is deliberately left out of reset; stale contents are hidden by the level count.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[w_ptr] <= bus.w_data;
    end

    assign r_ptr_pair  = r_ptr + ADDR_WIDTH'(1);
    assign first_word  = mem[r_ptr];
    assign second_word = mem[r_ptr_pair];

    assign bus.r_data = LOW_FIRST ? {second_word, first_word}
                                  : {first_word, second_word};

endmodule

// File: tb/tb_fifo_n2w.sv
// Self-checking bench for fifo_n2w: directed scenarios then randomized traffic,
// compared against a byte-queue reference model.
module tb_fifo_n2w;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic reset;

    fifo_n2w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_n2w #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stored narrow words in arrival order.
    logic [DW-1:0] model[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_level"}, 32'(bus.level), 32'(model.size()));
        check({tag, "_full"},  32'(bus.full),  32'(model.size() == DEPTH));
        check({tag, "_empty"}, 32'(bus.empty), 32'(model.size() < 2));
        if (model.size() >= 2)
            check({tag, "_rdata"}, 32'(bus.r_data), 32'({model[1], model[0]}));
    endtask

    task automatic applyReset();
        reset   = 1'b1;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        @(posedge clk);
        model.delete();
        #1;
        reset = 1'b0;
        checkOutput("reset");
    endtask

    // One clock of stimulus; acceptance is judged on the model's pre-edge occupancy.
    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                 input logic rst);
        bit wok;
        bit rok;
        bus.wr     = w;
        bus.w_data = d;
        bus.rd     = r;
        reset      = rst;
        wok = w && (model.size() < DEPTH);
        rok = r && (model.size() >= 2);
        @(posedge clk);
        if (rst) begin
            model.delete();
        end else begin
            if (rok) begin
                void'(model.pop_front());
                void'(model.pop_front());
            end
            if (wok)
                model.push_back(d);
        end
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        reset  = 1'b0;
        checkOutput("step");
    endtask

    initial begin
        reset      = 1'b1;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset state, read on empty ignored
        applyReset();
        check("s1_empty", 32'(bus.empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check("s1_level_after_rd", 32'(bus.level), 32'd0);

        // 2: orphan byte then completed word
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
        check("s2_orphan_empty", 32'(bus.empty), 32'd1);
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        check("s2_rdata", 32'(bus.r_data), 32'h1234);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // 3: fill, dropped write, drain in order
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        check("s3_full", 32'(bus.full), 32'd1);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        check("s3_level_after_drop", 32'(bus.level), 32'd8);
        check("s3_rd0", 32'(bus.r_data), 32'h0201);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check("s3_rd1", 32'(bus.r_data), 32'h0403);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check("s3_rd2", 32'(bus.r_data), 32'h0605);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check("s3_rd3", 32'(bus.r_data), 32'h0807);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check("s3_drained", 32'(bus.level), 32'd0);

        // 4: wrap-around with simultaneous write and read
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        check("s4_pre_rdata", 32'(bus.r_data), 32'hA2A1);
        applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
        check("s4_level", 32'(bus.level), 32'd2);
        check("s4_rdata", 32'(bus.r_data), 32'hA4A3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // 5: full with simultaneous write and read
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        check("s5_pre_rdata", 32'(bus.r_data), 32'h0201);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        check("s5_level", 32'(bus.level), 32'd6);
        check("s5_full", 32'(bus.full), 32'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // 6: reset mid-operation
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check("s6_pre_level", 32'(bus.level), 32'd5);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        check("s6_reset_level", 32'(bus.level), 32'd0);
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
        check("s6_rdata", 32'(bus.r_data), 32'h5678);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom),
                          1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
